ac97_stream_router: RTL and testbench

//  Parametrised successor to the fixed L/R loopback path between the AC97 datapath and the user DSP core.

---
 rtl/ac97_stream_router_if.sv | 22 ++
 rtl/ac97_stream_router.sv | 196 +++++++++++++++++++
 tb/tb_ac97_stream_router.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ac97_stream_router_if.sv
// Elastic valid/ready stream between the AC97 router and the user DSP core.
// master = router side, slave = DSP side.
interface ac97_stream_router_if #(
    parameter int unsigned W = 36
);
    logic [W-1:0] dsp_tx_data;
    logic         dsp_tx_valid;
    logic         dsp_tx_ready;
    logic [W-1:0] dsp_rx_data;
    logic         dsp_rx_valid;
    logic         dsp_rx_ready;

    modport master (
        output dsp_tx_data, dsp_tx_valid, dsp_rx_ready,
        input  dsp_tx_ready, dsp_rx_data, dsp_rx_valid
    );

    modport slave (
        input  dsp_tx_data, dsp_tx_valid, dsp_rx_ready,
        output dsp_tx_ready, dsp_rx_data, dsp_rx_valid
    );
endinterface

// File: rtl/ac97_stream_router.sv
// Routes NUM_CH AC97 sample lanes through loopback, DSP (FIFO-bridged), mute or test-tone modes,
// with per-lane arithmetic attenuation and saturating overrun/underrun counters.
module ac97_stream_router_fifo #(
    parameter int unsigned W  = 36,
    parameter int unsigned AW = 3
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    logic [W-1:0] r_mem [0:(2**AW)-1];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_dout  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + (AW+1)'(1);
            if (i_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_din;
    end
endmodule

module ac97_stream_router #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned FIFO_AW  = 3,
    parameter int unsigned TONE_DIV = 24
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     frame_strobe,
    input  logic [NUM_CH*DATA_W-1:0] codec_in,
    output logic [NUM_CH*DATA_W-1:0] codec_out,
    input  logic [1:0]               mode,
    input  logic [3:0]               atten,
    ac97_stream_router_if.master     dsp,
    output logic [7:0]               overrun_cnt,
    output logic [7:0]               underrun_cnt
);
    localparam int unsigned FW    = NUM_CH * DATA_W;
    localparam int unsigned CNT_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [DATA_W-1:0] TONE_POS = {2'b01, {(DATA_W-2){1'b0}}};
    localparam logic [DATA_W-1:0] TONE_NEG = {2'b11, {(DATA_W-2){1'b0}}};

    typedef enum logic [1:0] {
        MODE_LOOP = 2'd0,
        MODE_DSP  = 2'd1,
        MODE_MUTE = 2'd2,
        MODE_TONE = 2'd3
    } mode_e;

    mode_e            r_mode_q;
    mode_e            w_mode;
    logic             w_flush;
    logic             w_dsp_active;
    logic [CNT_W-1:0] r_tone_cnt;
    logic             r_tone_phase;
    logic [CNT_W-1:0] w_tone_cnt;
    logic             w_tone_phase;

    logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_drop;
    logic          w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [FW-1:0] w_tx_dout, w_rx_dout;
    logic [FW-1:0] w_src, w_next;
    logic          w_load;

    function automatic logic [DATA_W-1:0] f_atten(input logic [DATA_W-1:0] s, input logic [3:0] sh);
        logic signed [DATA_W-1:0] v;
        v = s;
        return v >>> sh;
    endfunction

    assign w_mode       = mode_e'(mode);
    assign w_flush      = (w_mode != r_mode_q);
    // FIFO traffic is suppressed in the flush cycle, including when entering DSP mode.
    assign w_dsp_active = (r_mode_q == MODE_DSP) && !w_flush;

    assign w_tone_cnt   = w_flush ? '0 : r_tone_cnt;
    assign w_tone_phase = w_flush ? 1'b0 : r_tone_phase;

    assign dsp.dsp_tx_valid = w_dsp_active && !w_tx_empty;
    assign dsp.dsp_tx_data  = w_tx_dout;
    assign w_tx_pop         = dsp.dsp_tx_valid && dsp.dsp_tx_ready;
    assign w_tx_push        = frame_strobe && w_dsp_active && (!w_tx_full || w_tx_pop);
    assign w_tx_drop        = frame_strobe && w_dsp_active && w_tx_full && !w_tx_pop;

    assign w_rx_pop         = frame_strobe && w_dsp_active && !w_rx_empty;
    assign dsp.dsp_rx_ready = w_dsp_active && (!w_rx_full || w_rx_pop);
    assign w_rx_push        = dsp.dsp_rx_valid && dsp.dsp_rx_ready;

    ac97_stream_router_fifo #(.W(FW), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .i_flush (w_flush),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_din   (codec_in),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    ac97_stream_router_fifo #(.W(FW), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .i_flush (w_flush),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_din   (dsp.dsp_rx_data),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_comb begin
        w_src  = '0;
        w_load = 1'b0;
        if (frame_strobe) begin
            unique case (w_mode)
                MODE_LOOP: begin
                    w_src  = codec_in;
                    w_load = 1'b1;
                end
                MODE_DSP: begin
                    w_src  = w_rx_dout;
                    w_load = w_rx_pop;
                end
                MODE_MUTE: begin
                    w_load = 1'b1;
                end
                MODE_TONE: begin
                    w_src  = {NUM_CH{w_tone_phase ? TONE_NEG : TONE_POS}};
                    w_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_next[k*DATA_W +: DATA_W] = f_atten(w_src[k*DATA_W +: DATA_W], atten);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_mode_q     <= MODE_LOOP;
            codec_out    <= '0;
            overrun_cnt  <= '0;
            underrun_cnt <= '0;
            r_tone_cnt   <= '0;
            r_tone_phase <= 1'b0;
        end else begin
            r_mode_q <= w_mode;
            if (w_load) codec_out <= w_next;
            if (w_tx_drop && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
            if (frame_strobe && w_dsp_active && w_rx_empty && (underrun_cnt != 8'hFF))
                underrun_cnt <= underrun_cnt + 8'd1;
            if (w_flush && (w_mode == MODE_TONE)) begin
                r_tone_cnt   <= '0;
                r_tone_phase <= 1'b0;
            end
            if (frame_strobe && (w_mode == MODE_TONE)) begin
                if (w_tone_cnt == CNT_W'(TONE_DIV - 1)) begin
                    r_tone_cnt   <= '0;
                    r_tone_phase <= ~w_tone_phase;
                end else begin
                    r_tone_cnt   <= w_tone_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ac97_stream_router.sv
// Directed bench for ac97_stream_router: loopback, attenuation, DSP FIFOs, flush, reset, tone, mute,
// counter saturation.
module tb_ac97_stream_router;
    localparam int unsigned DW = 18;
    localparam int unsigned FW = 36;

    logic          clk;
    logic          n_reset;
    logic          frame_strobe;
    logic [FW-1:0] codec_in;
    logic [FW-1:0] codec_out;
    logic [1:0]    mode;
    logic [3:0]    atten;
    logic [7:0]    overrun_cnt;
    logic [7:0]    underrun_cnt;

    int unsigned total;
    int unsigned bad;
    logic [FW-1:0] last_out;

    ac97_stream_router_if #(.W(FW)) bus ();

    ac97_stream_router #(
        .DATA_W   (DW),
        .NUM_CH   (2),
        .FIFO_AW  (3),
        .TONE_DIV (4)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .frame_strobe (frame_strobe),
        .codec_in     (codec_in),
        .codec_out    (codec_out),
        .mode         (mode),
        .atten        (atten),
        .dsp          (bus),
        .overrun_cnt  (overrun_cnt),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] fr(input logic [DW-1:0] l1, input logic [DW-1:0] l0);
        return {l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [FW-1:0] d);
        @(negedge clk);
        frame_strobe = 1'b1;
        codec_in     = d;
        @(negedge clk);
        frame_strobe = 1'b0;
    endtask

    task automatic rx_push(input logic [FW-1:0] d);
        bus.dsp_rx_valid = 1'b1;
        bus.dsp_rx_data  = d;
        @(negedge clk);
        bus.dsp_rx_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_reset = 1'b0;
        frame_strobe = 1'b0;
        codec_in = '0;
        mode = 2'd0;
        atten = 4'd0;
        bus.dsp_tx_ready = 1'b0;
        bus.dsp_rx_valid = 1'b0;
        bus.dsp_rx_data  = '0;
        tick(2);
        chk("rst_out", 64'(codec_out), 64'(0));
        chk("rst_txv", 64'(bus.dsp_tx_valid), 64'(0));
        chk("rst_rxr", 64'(bus.dsp_rx_ready), 64'(0));
        chk("rst_ovr", 64'(overrun_cnt), 64'(0));
        chk("rst_udr", 64'(underrun_cnt), 64'(0));
        n_reset = 1'b1;
        tick(2);

        // loopback, no attenuation
        for (int i = 0; i < 10; i++) begin
            strobe(fr(18'h3FFFF, 18'h00123 + 18'(i)));
            chk("t1_loop", 64'(codec_out), 64'(fr(18'h3FFFF, 18'h00123 + 18'(i))));
        end
        tick(2);
        chk("t1_hold", 64'(codec_out), 64'(fr(18'h3FFFF, 18'h0012C)));

        // attenuation
        atten = 4'd2;
        strobe(fr(18'h00007, 18'h20000));
        chk("t2_att2", 64'(codec_out), 64'(fr(18'h00001, 18'h38000)));
        atten = 4'd15;
        strobe(fr(18'h00001, 18'h3FFFF));
        chk("t2_att15", 64'(codec_out), 64'(fr(18'h00000, 18'h3FFFF)));
        last_out = fr(18'h00000, 18'h3FFFF);

        // DSP mode: TX fills to 8, two overruns, order kept on drain
        atten = 4'd0;
        mode  = 2'd1;
        tick(2);
        chk("t3_txv0", 64'(bus.dsp_tx_valid), 64'(0));
        chk("t3_rxr1", 64'(bus.dsp_rx_ready), 64'(1));
        for (int i = 0; i < 10; i++) strobe(fr(18'h00200 + 18'(i), 18'h00100 + 18'(i)));
        chk("t3_txv1", 64'(bus.dsp_tx_valid), 64'(1));
        chk("t3_ovr", 64'(overrun_cnt), 64'(2));
        chk("t3_udr", 64'(underrun_cnt), 64'(10));
        chk("t3_hold", 64'(codec_out), 64'(last_out));
        bus.dsp_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_drv", 64'(bus.dsp_tx_valid), 64'(1));
            chk("t3_drd", 64'(bus.dsp_tx_data), 64'(fr(18'h00200 + 18'(i), 18'h00100 + 18'(i))));
            tick(1);
        end
        chk("t3_empty", 64'(bus.dsp_tx_valid), 64'(0));
        bus.dsp_tx_ready = 1'b0;

        // underrun then RX data reaches codec_out
        for (int i = 0; i < 3; i++) strobe(fr(18'h00055, 18'h000AA));
        chk("t4_hold", 64'(codec_out), 64'(last_out));
        chk("t4_udr", 64'(underrun_cnt), 64'(13));
        atten = 4'd1;
        chk("t4_rxr", 64'(bus.dsp_rx_ready), 64'(1));
        rx_push(fr(18'h00100, 18'h3FFF0));
        strobe(fr(18'h00055, 18'h000AA));
        chk("t4_rxout", 64'(codec_out), 64'(fr(18'h00080, 18'h3FFF8)));
        chk("t4_udr2", 64'(underrun_cnt), 64'(13));
        atten = 4'd0;
        for (int i = 0; i < 8; i++) rx_push(fr(18'h00300 + 18'(i), 18'h00400 + 18'(i)));
        chk("t4_rxfull", 64'(bus.dsp_rx_ready), 64'(0));
        strobe(fr(18'h00055, 18'h000AA));
        chk("t4_q0", 64'(codec_out), 64'(fr(18'h00300, 18'h00400)));
        strobe(fr(18'h00055, 18'h000AA));
        chk("t4_q1", 64'(codec_out), 64'(fr(18'h00301, 18'h00401)));
        chk("t4_ovr", 64'(overrun_cnt), 64'(2));

        // mode change flush
        bus.dsp_tx_ready = 1'b1;
        tick(10);
        bus.dsp_tx_ready = 1'b0;
        chk("t6_drain", 64'(bus.dsp_tx_valid), 64'(0));
        for (int i = 0; i < 5; i++) strobe(fr(18'h00066, 18'h00077));
        chk("t6_txv", 64'(bus.dsp_tx_valid), 64'(1));
        chk("t6_q6", 64'(codec_out), 64'(fr(18'h00306, 18'h00406)));
        mode = 2'd0;
        tick(1);
        chk("t6_txv0", 64'(bus.dsp_tx_valid), 64'(0));
        chk("t6_rxr0", 64'(bus.dsp_rx_ready), 64'(0));
        chk("t6_hold", 64'(codec_out), 64'(fr(18'h00306, 18'h00406)));
        mode = 2'd1;
        tick(2);
        chk("t6_txflushed", 64'(bus.dsp_tx_valid), 64'(0));
        chk("t6_rxflushed", 64'(bus.dsp_rx_ready), 64'(1));

        // asynchronous reset mid-transfer
        rx_push(fr(18'h0ABCD, 18'h01234));
        strobe(fr(18'h00011, 18'h00022));
        chk("t6_pre_out", 64'(codec_out), 64'(fr(18'h0ABCD, 18'h01234)));
        chk("t6_pre_txv", 64'(bus.dsp_tx_valid), 64'(1));
        bus.dsp_rx_valid = 1'b1;
        bus.dsp_tx_ready = 1'b1;
        frame_strobe     = 1'b1;
        #2 n_reset = 1'b0;
        #1;
        chk("t6_rst_out", 64'(codec_out), 64'(0));
        chk("t6_rst_txv", 64'(bus.dsp_tx_valid), 64'(0));
        chk("t6_rst_rxr", 64'(bus.dsp_rx_ready), 64'(0));
        chk("t6_rst_ovr", 64'(overrun_cnt), 64'(0));
        chk("t6_rst_udr", 64'(underrun_cnt), 64'(0));
        frame_strobe     = 1'b0;
        bus.dsp_rx_valid = 1'b0;
        bus.dsp_tx_ready = 1'b0;
        mode = 2'd3;
        @(negedge clk);
        n_reset = 1'b1;
        tick(2);

        // tone: 4 frames positive, 4 negative, repeating
        for (int i = 0; i < 12; i++) begin
            strobe(fr(18'h0, 18'h0));
            chk("t5_tone", 64'(codec_out),
                64'(((i / 4) % 2 == 0) ? fr(18'h10000, 18'h10000) : fr(18'h30000, 18'h30000)));
        end
        atten = 4'd15;
        strobe(fr(18'h0, 18'h0));
        chk("t5_tone_att", 64'(codec_out), 64'(fr(18'h3FFFE, 18'h3FFFE)));
        atten = 4'd0;
        mode = 2'd2;
        tick(2);
        strobe(fr(18'h12345, 18'h01111));
        chk("mute", 64'(codec_out), 64'(0));
        mode = 2'd3;
        tick(2);
        strobe(fr(18'h0, 18'h0));
        chk("t5_reentry", 64'(codec_out), 64'(fr(18'h10000, 18'h10000)));

        // counter saturation
        mode = 2'd1;
        tick(2);
        for (int i = 0; i < 265; i++) strobe(fr(18'h00001, 18'h00002));
        chk("sat_udr", 64'(underrun_cnt), 64'(255));
        chk("sat_ovr", 64'(overrun_cnt), 64'(255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
